apc_sc_to_bin: RTL and testbench

Stochastic-to-binary decoder: sums the ones in an INUM-lane parallel stochastic bitstream over a window of 2^LOGLEN valid cycles and emits the exact binary count through a valid/ready output register. It is the receiving end of the parallel-counter adders. It turns their (or any SNG-fed) stochastic streams back into binary for result checking and for the binary domain. Windows run back-to-back with no dead cycles.

---
 rtl/apc_pkg.sv | 17 +
 rtl/apc_sc_to_bin_if.sv | 23 ++
 rtl/apc_popcount.sv | 17 +
 rtl/apc_sc_to_bin.sv | 103 ++++++++++
 tb/tb_apc_sc_to_bin.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/apc_pkg.sv
// rtl/apc_pkg.sv - shared APC constants, state type and width helper
package apc_pkg;

  localparam int APC_INUM    = 16;
  localparam int APC_LOGINUM = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Output width that holds the full-scale count INUM * 2^LOGLEN.
  function automatic int apc_ow(input int loginum, input int loglen);
    return loginum + loglen + 1;
  endfunction

endpackage

// File: rtl/apc_sc_to_bin_if.sv
// rtl/apc_sc_to_bin_if.sv - stochastic sample input and binary result handshake
interface apc_sc_to_bin_if #(
  parameter int INUM = 16,
  parameter int OW   = 13
);

  logic [INUM-1:0] in;
  logic            in_valid;
  logic [OW-1:0]   out;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in, in_valid, out_ready,
    input  out, out_valid
  );

  modport slave (
    input  in, in_valid, out_ready,
    output out, out_valid
  );

endinterface

// File: rtl/apc_popcount.sv
// rtl/apc_popcount.sv - combinational exact ones counter over INUM lanes
module apc_popcount #(
  parameter int INUM    = 16,
  parameter int LOGINUM = 4
) (
  input  logic [INUM-1:0]  bits,
  output logic [LOGINUM:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < INUM; i++) begin
      count = count + (LOGINUM + 1)'(bits[i]);
    end
  end

endmodule

// File: rtl/apc_sc_to_bin.sv
// rtl/apc_sc_to_bin.sv - windowed stochastic-to-binary decoder with result register
module apc_sc_to_bin
  import apc_pkg::*;
#(
  parameter int INUM    = APC_INUM,
  parameter int LOGINUM = APC_LOGINUM,
  parameter int LOGLEN  = 8,
  parameter int OW      = apc_ow(LOGINUM, LOGLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  apc_sc_to_bin_if.slave  bus,
  output logic            overrun,
  output logic            busy
);

  state_t              state, state_nxt;
  logic [LOGLEN-1:0]   scnt;
  logic [LOGINUM:0]    pc_comb, pcnt;
  logic                pv, plast;
  logic [OW-2:0]       acc;
  logic [OW-1:0]       out_q;
  logic                out_valid_q;
  logic                clr, accept, load;

  apc_popcount #(.INUM(INUM), .LOGINUM(LOGINUM)) u_popcount (
    .bits  (bus.in),
    .count (pc_comb)
  );

  // start/stop squash everything in flight, including a pending last sample.
  assign clr    = start | stop;
  assign accept = (state == RUN) && bus.in_valid && !clr;
  assign load   = pv && plast && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)     state_nxt = RUN;
    else if (stop) state_nxt = IDLE;
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt  <= '0;
      pcnt  <= '0;
      pv    <= 1'b0;
      plast <= 1'b0;
    end else if (clr) begin
      scnt  <= '0;
      pcnt  <= '0;
      pv    <= 1'b0;
      plast <= 1'b0;
    end else if (accept) begin
      pcnt  <= pc_comb;
      pv    <= 1'b1;
      plast <= &scnt;
      scnt  <= scnt + 1'b1;
    end else begin
      pv    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 acc <= '0;
    else if (clr)            acc <= '0;
    else if (pv && plast)    acc <= '0;
    else if (pv)             acc <= acc + (OW - 1)'(pcnt);
  end

  // A load beats a same-edge handshake: the new result simply replaces the old.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_q       <= OW'(acc) + OW'(pcnt);
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     overrun <= 1'b0;
    else if (start)                              overrun <= 1'b0;
    else if (load && out_valid_q && !bus.out_ready) overrun <= 1'b1;
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_apc_sc_to_bin.sv
// tb/tb_apc_sc_to_bin.sv - scoreboard bench for apc_sc_to_bin (INUM=16, LOGLEN=3)
module tb_apc_sc_to_bin;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic overrun, busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  apc_sc_to_bin_if #(.INUM(16), .OW(8)) bus_if ();

  apc_sc_to_bin #(.INUM(16), .LOGINUM(4), .LOGLEN(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .bus     (bus_if),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a handshake happens at the next rising edge whenever this holds.
  always @(negedge clk) begin
    if (!rst && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %0d expected none", bus_if.out);
      end else begin
        chk("result", 32'(bus_if.out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic samples(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.in = d;
      bus_if.in_valid = 1'b1;
      step();
    end
    bus_if.in_valid = 1'b0;
  endtask

  initial begin
    bus_if.in = '0;
    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    step();
    step();
    chk("reset_out", 32'(bus_if.out), 0);
    chk("reset_out_valid", 32'(bus_if.out_valid), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    step();

    // Full-scale window then an all-zero window back to back
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    exp_q.push_back(8'd128);
    exp_q.push_back(8'd0);
    for (int i = 0; i < 16; i++) begin
      bus_if.in = (i < 8) ? 16'hFFFF : 16'h0000;
      bus_if.in_valid = 1'b1;
      step();
      if (i == 7) chk("latency_not_yet", 32'(bus_if.out_valid), 0);
      if (i == 8) begin
        chk("latency_valid", 32'(bus_if.out_valid), 1);
        chk("latency_out", 32'(bus_if.out), 128);
      end
      if (i == 9) chk("valid_one_cycle", 32'(bus_if.out_valid), 0);
    end
    bus_if.in_valid = 1'b0;
    repeat (3) step();

    // in_valid gaps must not count toward the window
    exp_q.push_back(8'd64);
    for (int i = 0; i < 16; i++) begin
      bus_if.in = 16'h00FF;
      bus_if.in_valid = (i % 2 == 0);
      step();
    end
    bus_if.in_valid = 1'b0;
    repeat (3) step();

    // Unconsumed result overwritten -> overrun; start clears it
    bus_if.out_ready = 1'b0;
    samples(16'h0001, 16);
    repeat (3) step();
    chk("overrun_valid", 32'(bus_if.out_valid), 1);
    chk("overrun_out", 32'(bus_if.out), 8);
    chk("overrun_set", 32'(overrun), 1);
    exp_q.push_back(8'd8);
    bus_if.out_ready = 1'b1;
    step();
    pulse_start();
    chk("overrun_cleared", 32'(overrun), 0);

    // stop discards a partial window; inputs ignored in IDLE
    samples(16'hFFFF, 5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("busy_after_stop", 32'(busy), 0);
    samples(16'hFFFF, 3);
    pulse_start();
    exp_q.push_back(8'd32);
    samples(16'h000F, 8);
    repeat (3) step();

    // start on the same edge as the last sample: no result
    samples(16'h0001, 7);
    bus_if.in = 16'h0001;
    bus_if.in_valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    bus_if.in_valid = 1'b0;
    repeat (3) step();
    chk("start_at_last_no_result", 32'(bus_if.out_valid), 0);

    // start while the last sample is in flight: no result
    samples(16'h0001, 8);
    pulse_start();
    repeat (3) step();
    chk("start_inflight_no_result", 32'(bus_if.out_valid), 0);

    // Handshake on the edge a new result loads
    bus_if.out_ready = 1'b0;
    exp_q.push_back(8'd16);
    for (int i = 0; i < 16; i++) begin
      bus_if.in = (i < 8) ? 16'h0003 : 16'h0007;
      bus_if.in_valid = 1'b1;
      step();
    end
    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    exp_q.push_back(8'd24);
    step();
    chk("same_edge_valid", 32'(bus_if.out_valid), 1);
    chk("same_edge_out", 32'(bus_if.out), 24);
    chk("same_edge_no_overrun", 32'(overrun), 0);
    step();
    chk("same_edge_consumed", 32'(bus_if.out_valid), 0);

    // Async reset mid-window with a held result
    bus_if.out_ready = 1'b0;
    samples(16'h0001, 11);
    repeat (2) step();
    chk("pre_reset_valid", 32'(bus_if.out_valid), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(bus_if.out), 0);
    chk("async_rst_valid", 32'(bus_if.out_valid), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_overrun", 32'(overrun), 0);
    step();
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    samples(16'hFFFF, 10);
    repeat (3) step();
    chk("idle_ignores_in_valid", 32'(bus_if.out_valid), 0);
    chk("idle_busy", 32'(busy), 0);

    repeat (2) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
